// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, FSM states and header field positions for the SPI command decoder.
package spi_cmd_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;

  localparam int FIELD_BITS = 8;
  localparam int OPCODE_LSB = 56;
  localparam int ADDR_LSB   = 48;
  localparam int COUNT_LSB  = 40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR_PAYLOAD,
    ST_RD_RESP
  } spi_cmd_state_t;

endpackage

// File: rtl/rising_edge_detector.sv
// Rising-edge detector on a level input, with an optional two-flop synchronizer
// for inputs that arrive asynchronously to clk.
module rising_edge_detector #(
  parameter bit SYNC = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);

  logic synced;
  logic prev;

  generate
    if (SYNC) begin : g_sync
      logic [1:0] sync_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], sig};
      end
      assign synced = sync_q[1];
    end else begin : g_direct
      assign synced = sig;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= synced;
  end

  assign rise = synced & ~prev;

endmodule

// File: rtl/spi_cmd_regfile.sv
// NUM_REGS x DATA_BITS register file: one synchronous write port, one
// asynchronous read port, and every entry exposed on a flattened bus.
module spi_cmd_regfile #(
  parameter int NUM_REGS  = 16,
  parameter int DATA_BITS = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          we,
  input  logic [$clog2(NUM_REGS)-1:0]   waddr,
  input  logic [DATA_BITS-1:0]          wdata,
  input  logic [$clog2(NUM_REGS)-1:0]   raddr,
  output logic [DATA_BITS-1:0]          rdata,
  output logic [NUM_REGS*DATA_BITS-1:0] regs_flat
);

  logic [DATA_BITS-1:0] mem [NUM_REGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
      assign regs_flat[DATA_BITS*i +: DATA_BITS] = mem[i];
    end
  endgenerate

endmodule

// File: rtl/spi_command_decoder.sv
// Frames SPI words into header/payload commands, owns the register file and
// chooses the word shifted back to the host on the next transfer.
module spi_command_decoder
  import spi_cmd_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int WORD_BITS = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cs,
  input  logic                          word_received,
  input  logic [WORD_BITS-1:0]          word_data_received,
  input  logic [WORD_BITS-1:0]          status_in,
  output logic [WORD_BITS-1:0]          word_send_data,
  output logic [NUM_REGS*WORD_BITS-1:0] regs_flat,
  output logic                          write_strobe,
  output logic [$clog2(NUM_REGS)-1:0]   write_addr,
  output logic [7:0]                    error_count
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  logic                 word_rise;
  logic                 cs_rise;
  logic                 word_event;
  logic [WORD_BITS-1:0] data_q;

  spi_cmd_state_t       state, state_d;
  logic [ADDR_W-1:0]    wr_ptr, wr_ptr_d;
  logic [7:0]           remaining, remaining_d;
  logic [WORD_BITS-1:0] send_d;
  logic [7:0]           err_d;
  logic                 we;
  logic                 resp_loaded;
  logic [WORD_BITS-1:0] rd_data;

  logic [7:0]           opcode, hdr_addr, hdr_count, count_eff;
  logic                 addr_ok, hdr_bad;

  rising_edge_detector #(.SYNC(1'b0)) u_word_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (word_received),
    .rise  (word_rise)
  );

  rising_edge_detector #(.SYNC(1'b1)) u_cs_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (cs),
    .rise  (cs_rise)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_event <= 1'b0;
      data_q     <= '0;
    end else begin
      word_event <= word_rise;
      if (word_rise) data_q <= word_data_received;
    end
  end

  assign opcode    = data_q[OPCODE_LSB +: FIELD_BITS];
  assign hdr_addr  = data_q[ADDR_LSB +: FIELD_BITS];
  assign hdr_count = data_q[COUNT_LSB +: FIELD_BITS];
  assign count_eff = (hdr_count == 8'd0) ? 8'd1 : hdr_count;
  assign addr_ok   = ({1'b0, hdr_addr} < 9'(NUM_REGS));
  // Only WRITE and READ carry a register address worth range-checking.
  assign hdr_bad   = (opcode > OP_STATUS) ||
                     (((opcode == OP_WRITE) || (opcode == OP_READ)) && !addr_ok);

  spi_cmd_regfile #(.NUM_REGS(NUM_REGS), .DATA_BITS(WORD_BITS)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .waddr     (wr_ptr),
    .wdata     (data_q),
    .raddr     (hdr_addr[ADDR_W-1:0]),
    .rdata     (rd_data),
    .regs_flat (regs_flat)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      wr_ptr         <= '0;
      remaining      <= 8'd0;
      word_send_data <= '0;
      error_count    <= 8'd0;
      write_strobe   <= 1'b0;
      write_addr     <= '0;
    end else begin
      state          <= state_d;
      wr_ptr         <= wr_ptr_d;
      remaining      <= remaining_d;
      word_send_data <= send_d;
      error_count    <= err_d;
      write_strobe   <= we;
      if (we) write_addr <= wr_ptr;
    end
  end

  always_comb begin
    state_d     = state;
    wr_ptr_d    = wr_ptr;
    remaining_d = remaining;
    send_d      = word_send_data;
    err_d       = error_count;
    we          = 1'b0;
    resp_loaded = 1'b0;

    if (word_event) begin
      case (state)
        ST_IDLE: begin
          if (hdr_bad) begin
            err_d = (error_count == 8'hFF) ? error_count : error_count + 8'd1;
          end else begin
            case (opcode)
              OP_NOP: ;
              OP_WRITE: begin
                wr_ptr_d    = hdr_addr[ADDR_W-1:0];
                remaining_d = count_eff;
                state_d     = ST_WR_PAYLOAD;
              end
              OP_READ: begin
                send_d      = rd_data;
                resp_loaded = 1'b1;
                state_d     = ST_RD_RESP;
              end
              OP_STATUS: begin
                send_d      = status_in;
                resp_loaded = 1'b1;
                state_d     = ST_RD_RESP;
              end
              default: ;
            endcase
          end
        end
        ST_WR_PAYLOAD: begin
          we          = 1'b1;
          wr_ptr_d    = wr_ptr + 1'b1;
          remaining_d = remaining - 8'd1;
          if (remaining_d == 8'd0) state_d = ST_IDLE;
        end
        ST_RD_RESP: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      if (!resp_loaded) send_d = {err_d, {(WORD_BITS-8){1'b0}}};
    end

    // A chip-select release abandons the frame after any same-cycle word is handled.
    if (cs_rise) begin
      state_d     = ST_IDLE;
      remaining_d = 8'd0;
      send_d      = {err_d, {(WORD_BITS-8){1'b0}}};
    end
  end

endmodule

// File: tb/tb_spi_command_decoder.sv
// Directed, table-driven bench for spi_command_decoder (NUM_REGS = 16).
module tb_spi_command_decoder;

  localparam int NUM_REGS = 16;
  localparam logic [63:0] STATUS_VAL = 64'h5A5A_0123_4567_89AB;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cs;
  logic                 word_received;
  logic [63:0]          word_data_received;
  logic [63:0]          status_in;
  logic [63:0]          word_send_data;
  logic [NUM_REGS*64-1:0] regs_flat;
  logic                 write_strobe;
  logic [3:0]           write_addr;
  logic [7:0]           error_count;

  int tests_run = 0;
  int tests_failed = 0;
  int strobe_total = 0;

  typedef struct {
    logic [63:0] word;
    logic        exp_strobe;
    logic [3:0]  exp_addr;
    logic [63:0] exp_send;
    logic [7:0]  exp_err;
  } vec_t;

  vec_t vecs[18];

  spi_command_decoder #(.NUM_REGS(NUM_REGS), .WORD_BITS(64)) dut (
    .clk                (clk),
    .reset              (reset),
    .cs                 (cs),
    .word_received      (word_received),
    .word_data_received (word_data_received),
    .status_in          (status_in),
    .word_send_data     (word_send_data),
    .regs_flat          (regs_flat),
    .write_strobe       (write_strobe),
    .write_addr         (write_addr),
    .error_count        (error_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (write_strobe) strobe_total++;

  function automatic logic [63:0] reg_at(input int idx);
    return regs_flat[64*idx +: 64];
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Presents one word from the receiver and samples outputs once the decoder has consumed it.
  task automatic apply_stimulus(input logic [63:0] w, output logic strobe, output logic [3:0] addr);
    @(negedge clk);
    word_data_received = w;
    word_received = 1'b1;
    @(negedge clk);
    word_received = 1'b0;
    @(posedge clk);
    #1;
    strobe = write_strobe;
    addr = write_addr;
  endtask

  initial begin
    logic       s;
    logic [3:0] a;

    vecs[0]  = '{64'h0103_01AB_CDEF_1234, 1'b0, 4'd0,  64'h0,                   8'd0};
    vecs[1]  = '{64'h1122_3344_5566_7788, 1'b1, 4'd3,  64'h0,                   8'd0};
    vecs[2]  = '{64'h010E_0400_0000_0000, 1'b0, 4'd0,  64'h0,                   8'd0};
    vecs[3]  = '{64'hA0A0_A0A0_0000_0001, 1'b1, 4'd14, 64'h0,                   8'd0};
    vecs[4]  = '{64'hB0B0_B0B0_0000_0002, 1'b1, 4'd15, 64'h0,                   8'd0};
    vecs[5]  = '{64'hC0C0_C0C0_0000_0003, 1'b1, 4'd0,  64'h0,                   8'd0};
    vecs[6]  = '{64'hD0D0_D0D0_0000_0004, 1'b1, 4'd1,  64'h0,                   8'd0};
    vecs[7]  = '{64'h0105_0000_0000_0000, 1'b0, 4'd0,  64'h0,                   8'd0};
    vecs[8]  = '{64'hDEAD_BEEF_CAFE_F00D, 1'b1, 4'd5,  64'h0,                   8'd0};
    vecs[9]  = '{64'h0205_0000_0000_0000, 1'b0, 4'd0,  64'hDEAD_BEEF_CAFE_F00D, 8'd0};
    vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd0,  64'h0,                   8'd0};
    vecs[11] = '{64'h0300_0000_0000_0000, 1'b0, 4'd0,  STATUS_VAL,              8'd0};
    vecs[12] = '{64'h0000_0000_0000_0000, 1'b0, 4'd0,  64'h0,                   8'd0};
    vecs[13] = '{64'h7F00_0000_0000_0000, 1'b0, 4'd0,  64'h0100_0000_0000_0000, 8'd1};
    vecs[14] = '{64'h0214_0000_0000_0000, 1'b0, 4'd0,  64'h0200_0000_0000_0000, 8'd2};
    vecs[15] = '{64'h0000_0000_0000_0000, 1'b0, 4'd0,  64'h0200_0000_0000_0000, 8'd2};
    vecs[16] = '{64'h0203_0000_0000_0000, 1'b0, 4'd0,  64'h1122_3344_5566_7788, 8'd2};
    vecs[17] = '{64'h0000_0000_0000_0000, 1'b0, 4'd0,  64'h0200_0000_0000_0000, 8'd2};

    reset = 1'b1;
    cs = 1'b0;
    word_received = 1'b0;
    word_data_received = '0;
    status_in = STATUS_VAL;
    repeat (3) @(negedge clk);
    check_output("reset_send", word_send_data, 64'h0);
    check_output("reset_err", 64'(error_count), 64'h0);
    check_output("reset_strobe", 64'(write_strobe), 64'h0);
    check_output("reset_waddr", 64'(write_addr), 64'h0);
    check_output("reset_regs_zero", 64'(regs_flat == '0), 64'h1);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      apply_stimulus(vecs[i].word, s, a);
      check_output($sformatf("vec%0d_strobe", i), 64'(s), 64'(vecs[i].exp_strobe));
      if (vecs[i].exp_strobe) check_output($sformatf("vec%0d_waddr", i), 64'(a), 64'(vecs[i].exp_addr));
      check_output($sformatf("vec%0d_send", i), word_send_data, vecs[i].exp_send);
      check_output($sformatf("vec%0d_err", i), 64'(error_count), 64'(vecs[i].exp_err));
    end

    check_output("reg3", reg_at(3), 64'h1122_3344_5566_7788);
    check_output("reg14", reg_at(14), 64'hA0A0_A0A0_0000_0001);
    check_output("reg15", reg_at(15), 64'hB0B0_B0B0_0000_0002);
    check_output("reg0", reg_at(0), 64'hC0C0_C0C0_0000_0003);
    check_output("reg1", reg_at(1), 64'hD0D0_D0D0_0000_0004);
    check_output("reg5", reg_at(5), 64'hDEAD_BEEF_CAFE_F00D);
    check_output("reg2_untouched", reg_at(2), 64'h0);
    check_output("strobes_after_table", 64'(strobe_total), 64'd6);

    // Chip-select release mid-write: the next header must not be taken as payload.
    apply_stimulus(64'h0108_0300_0000_0000, s, a);
    check_output("cs_hdr_strobe", 64'(s), 64'h0);
    apply_stimulus(64'h0123_4567_89AB_CDEF, s, a);
    check_output("cs_pay_strobe", 64'(s), 64'h1);
    check_output("cs_pay_waddr", 64'(a), 64'd8);
    @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    check_output("cs_idle_resp", word_send_data, 64'h0200_0000_0000_0000);
    apply_stimulus(64'h0208_0000_0000_0000, s, a);
    check_output("cs_read_no_strobe", 64'(s), 64'h0);
    check_output("cs_read_resp", word_send_data, 64'h0123_4567_89AB_CDEF);
    apply_stimulus(64'h0, s, a);
    check_output("cs_dummy_resp", word_send_data, 64'h0200_0000_0000_0000);
    check_output("cs_reg9_untouched", reg_at(9), 64'h0);
    check_output("cs_strobe_total", 64'(strobe_total), 64'd7);

    // Asynchronous reset after two of four payload words.
    apply_stimulus(64'h010A_0400_0000_0000, s, a);
    apply_stimulus(64'h1010_1010_1010_1010, s, a);
    apply_stimulus(64'h1111_1111_1111_1111, s, a);
    check_output("rst_pre_reg10", reg_at(10), 64'h1010_1010_1010_1010);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_output("rst_regs_zero", 64'(regs_flat == '0), 64'h1);
    check_output("rst_send", word_send_data, 64'h0);
    check_output("rst_err", 64'(error_count), 64'h0);
    check_output("rst_strobe", 64'(write_strobe), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(64'h0102_0100_0000_0000, s, a);
    check_output("rst_hdr_strobe", 64'(s), 64'h0);
    apply_stimulus(64'h2222_3333_4444_5555, s, a);
    check_output("rst_pay_strobe", 64'(s), 64'h1);
    check_output("rst_pay_waddr", 64'(a), 64'd2);
    check_output("rst_reg2", reg_at(2), 64'h2222_3333_4444_5555);
    check_output("rst_reg12", reg_at(12), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_command_decoder.md
# spi_command_decoder

Consumes 64-bit little-endian words from the SPI word receiver. Frames them into header/payload commands and maintains a `NUM_REGS`-entry × 64-bit register file. It drives the receiver's transmit word so read responses and status return to the host in the next SPI word. It is the link between the SPI word layer and the motion/config registers of the core.

## Interface
- `NUM_REGS`, 16: register-file depth; power of two, 2..256.
- `WORD_BITS`, 64: SPI word width; only 64 is supported.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `cs` in 1: raw SPI chip select, active low. Synchronized internally with 2 flops.
- `word_received` in 1: level from the word receiver. A rising edge marks one completed word.
- `word_data_received` in 64: completed word; valid on the `word_received` rising edge.
- `status_in` in 64: live status returned by the STATUS command.
- `word_send_data` out 64: word shifted to the host during the next transfer.
- `regs_flat` out `NUM_REGS*64`: register file; entry i is `[64*i+63:64*i]`.
- `write_strobe` out 1: one-cycle pulse per register write.
- `write_addr` out `$clog2(NUM_REGS)`: address of the current write; valid with `write_strobe`.
- `error_count` out 8: saturating count of rejected headers.

## Operation
- **Word event:** a rising edge of `word_received`, detected with one delay flop. Data is captured in the same cycle.
- **Header fields:**
  - opcode = `[63:56]`
  - addr = `[55:48]`
  - count = `[47:40]`; count 0 is treated as 1
  - bits `[39:0]` are ignored
- **Opcodes:**
  - NOP `0x00`
  - WRITE `0x01`
  - READ `0x02`
  - STATUS `0x03`
- **FSM states:** IDLE, WR_PAYLOAD, RD_RESP.
- **IDLE + header:**
  - NOP: stay in IDLE.
  - WRITE: load `wr_ptr`=addr and `remaining`=count, then go to WR_PAYLOAD.
  - READ: `word_send_data`←reg[addr], then go to RD_RESP.
  - STATUS: `word_send_data`←`status_in` (sampled that cycle), then go to RD_RESP.
  - Unknown opcode, or addr ≥ `NUM_REGS`: `error_count`+1 (saturate at 255), stay in IDLE.
- **WR_PAYLOAD + word:**
  - reg[`wr_ptr`]←word; pulse `write_strobe` with `write_addr`=`wr_ptr`.
  - `wr_ptr`←(`wr_ptr`+1) mod `NUM_REGS`; wrap-around is legal.
  - `remaining`−1; at 0, go to IDLE.
- **RD_RESP + word:** the incoming word is ignored (dummy). Go to IDLE and restore the idle response.
- **Idle response:** `{error_count, 56'h0}`. It is loaded on entry to IDLE and on every word that does not load a response.
- **CS deassert:** when synchronized `cs` goes high, the FSM goes to IDLE in the next cycle. `remaining` is cleared, the idle response is loaded, and registers are untouched. A partially sent frame is abandoned without error.
- A word event and a CS rising edge in the same cycle: the word is processed first, then the abort applies.

## Timing
- **Reset values:**
  - state IDLE
  - `word_send_data`=0
  - all regs 0
  - `write_strobe`=0, `write_addr`=0
  - `error_count`=0
- **Edge detection:** word event asserted 1 cycle after the `word_received` rising edge.
- **Register update and strobe:** both visible 1 cycle after the word event (2 cycles after `word_received` rises).
- **Response:** `word_send_data` is updated 1 cycle after the word event. It must be stable before the receiver samples byte 0 of the next word. Host SCK of at most `clk`/8 guarantees this.
- No back-pressure: every word event is consumed in exactly one cycle.
- Reset mid-frame: everything returns to reset values immediately (asynchronous).

## Structure
- Package `spi_cmd_pkg` holds:
  - opcode localparams (`OP_NOP`, `OP_WRITE`, `OP_READ`, `OP_STATUS`)
  - FSM state enum `spi_cmd_state_t`
  - header field bit positions
- One sub-module, `spi_cmd_regfile`:
  - `NUM_REGS`×64 storage
  - synchronous write port, asynchronous read port
  - flattened output
- Edge and CS synchronization reuse the existing `rising_edge_detector`.

## Test plan
- **Single write:**
  - Stimulus: header `0x01_03_01_..`, then payload `0x1122334455667788`.
  - Required: reg[3]=`0x1122334455667788`, one `write_strobe` with `write_addr`=3, state IDLE.
- **Burst with wrap:**
  - Stimulus: header addr=14, count=4, `NUM_REGS`=16, payload words A, B, C, D.
  - Required: reg14=A, reg15=B, reg0=C, reg1=D; 4 strobes.
- **Read:**
  - Stimulus: preload reg5=`0xDEADBEEFCAFEF00D`; READ addr 5, then a dummy word.
  - Required: host receives `0xDEADBEEFCAFEF00D` during the dummy word. The following word returns `{8'h00, 56'h0}`.
- **Errors:**
  - Stimulus: opcode `0x7F`, then READ addr 20 with `NUM_REGS`=16.
  - Required: `error_count`=2, no writes, and the idle response reads `0x02000000_00000000`.
- **CS abort:**
  - Stimulus: WRITE count=3 with 1 payload word, then `cs` high, then a new READ header.
  - Required: exactly 1 write; the READ is decoded as a header, not as payload.
- **Async reset mid-burst:**
  - Stimulus: assert `reset` after 2 of 4 payload words.
  - Required: all regs 0, state IDLE, `word_send_data`=0 immediately after reset asserts.
